// File: rtl/pts_word_sr.sv
// pts_word_sr -- N-word parallel-to-serial shift register with a valid/ready
// output handshake.
//
// A full frame of NUM_WORDS 32-bit words is captured in one cycle. The words
// are then streamed out one per accepted handshake, highest index first.
// Feeding serial_out into a serial-to-parallel register that shifts on
// out_valid & out_ready rebuilds the original array index-for-index.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   clear        synchronous abort, drops the current frame (no done pulse)
//   load_enable  capture parallel_in (only honoured while load_ready)
//   parallel_in  frame words, [NUM_WORDS-1:0] x 32
//   load_ready   idle, a load will be accepted
//   serial_out   current outgoing word
//   out_valid    serial_out holds a valid word
//   out_ready    downstream accepts serial_out this cycle
//   out_last     serial_out is the final word of the frame
//   words_left   words of the current frame not yet accepted
//   done         one-cycle pulse after the final word is accepted
module pts_word_sr #(
   parameter int unsigned NUM_WORDS = 8,
   parameter int unsigned CW        = $clog2(NUM_WORDS + 1)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          clear,
   input  logic          load_enable,
   input  logic [31:0]   parallel_in [NUM_WORDS-1:0],
   output logic          load_ready,
   output logic [31:0]   serial_out,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic [CW-1:0] words_left,
   output logic          done
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]    state;
   logic [31:0]   word [NUM_WORDS-1:0];
   logic [CW-1:0] count;
   logic          done_q;
   logic          last;

   assign last = (count == CW'(1));

   // Every output is decoded from registers; out_ready only steers next state.
   assign load_ready = (state == IDLE);
   assign out_valid  = (state == SHIFT);
   assign serial_out = word[NUM_WORDS-1];
   assign out_last   = last;
   assign words_left = count;
   assign done       = done_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= IDLE;
         count  <= '0;
         done_q <= 1'b0;
         for (int unsigned i = 0; i < NUM_WORDS; i++) word[i] <= '0;
      end else begin
         done_q <= 1'b0;
         if (clear) begin
            state <= IDLE;
            count <= '0;
            for (int unsigned i = 0; i < NUM_WORDS; i++) word[i] <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (load_enable) begin
                     for (int unsigned i = 0; i < NUM_WORDS; i++) word[i] <= parallel_in[i];
                     count <= CW'(NUM_WORDS);
                     state <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (out_ready) begin
                     // Shift toward the top; zeros fill from index 0 so the
                     // registers are empty once the frame has drained.
                     for (int unsigned i = 1; i < NUM_WORDS; i++) word[i] <= word[i-1];
                     word[0] <= '0;
                     count   <= count - CW'(1);
                     if (last) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
